grf_multiport: RTL and testbench
================================

GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning that when 1, register 0 reads 0 and ignores writes and busy-sets.
REQ-004 SHALL have parameter BYPASS, default 1, meaning that when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have ports A1 and A2, input, ADDR_W bits each, read addresses.
REQ-008 SHALL have ports Rd1 and Rd2, output, DATA_W bits each, read data, combinational.
REQ-009 SHALL have ports A3, Wd3 and We3, input, ADDR_W/DATA_W/1 bits, write port 0.
REQ-010 SHALL have ports A4, Wd4 and We4, input, ADDR_W/DATA_W/1 bits, write port 1, which has priority over port 0.
REQ-011 SHALL have ports SetBusy (input, 1 bit) and SetAddr (input, ADDR_W bits), which mark a register as pending a write.
REQ-012 SHALL have ports Busy1 and Busy2, output, 1 bit each, the pending flag of A1/A2, combinational from state.
REQ-013 SHALL have port Collision, output, 1 bit, registered; flags a same-address dual write in the previous cycle.

Function
REQ-014 SHALL hold an array of 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-015 A write SHALL be "effective" when its We is 1, Reset is 0, and the address is not 0 (when ZERO_REG=1).
REQ-016 An effective write SHALL update its register at the rising edge; latency is 1 cycle to the stored value.
REQ-017 When both writes are effective to the same address, Wd4 SHALL be stored and Wd3 discarded.
REQ-018 When the two writes go to different addresses, both SHALL be stored in the same cycle.
REQ-019 Rd1/Rd2 SHALL equal the stored register at A1/A2; when ZERO_REG=1 and the address is 0, they SHALL equal 0 regardless of state.
REQ-020 When BYPASS=1 and an effective write targets A1 (or A2), Rd1 (Rd2) SHALL return that write's data, with port 1 taking precedence; when BYPASS=0, the old value is returned until the next cycle.
REQ-021 An effective write SHALL clear the busy bit of its address at the edge.
REQ-022 SetBusy=1 SHALL set busy[SetAddr] at the edge, except address 0 when ZERO_REG=1.
REQ-023 When SetBusy and an effective write target the same address in one cycle, set SHALL win and the busy bit ends at 1.
REQ-024 Busy1/Busy2 SHALL reflect stored busy bits only, not same-cycle set/clear; they SHALL read 0 for address 0 when ZERO_REG=1.
REQ-025 Collision SHALL be 1 in the cycle after both writes were effective to the same address, and 0 otherwise.
REQ-026 Address comparisons SHALL use the full ADDR_W bits; no wrap or aliasing is permitted.

Reset
REQ-027 When Reset=1 at an edge, all registers SHALL become 0, all busy bits 0, and Collision 0; writes and SetBusy in that cycle SHALL be ignored.
REQ-028 Reset asserted while writes or busy bits are pending SHALL discard them; the first post-reset cycle SHALL read all zeros and not busy.
REQ-029 All state SHALL also be initialised to 0 at time zero for simulation.

Verification
REQ-030 Reset, then We3=1, A3=5, Wd3=0x1234; next cycle A1=5 -> Rd1=0x1234; in the write cycle, Rd1=0x1234 if BYPASS=1, else 0.
REQ-031 We3=We4=1, A3=A4=7, Wd3=0xAAAA, Wd4=0x5555 -> reg7=0x5555 and Collision=1 for exactly one cycle.
REQ-032 With ZERO_REG=1: We4=1, A4=0, Wd4=0xFFFF plus SetBusy to address 0 -> Rd1 at A1=0 reads 0 and Busy1=0.
REQ-033 SetBusy with SetAddr=9 -> Busy2=1 at A2=9; later We3 to 9 -> Busy2=0 the next cycle; SetBusy and a write to 9 in the same cycle -> Busy2 stays 1.
REQ-034 Load regs 1..31 with nonzero data and busy bits, then pulse Reset for one cycle mid-write -> all Rd=0, all Busy=0, Collision=0.
REQ-035 Parameter sweep DATA_W=8, ADDR_W=3, BYPASS=0: write 0xC3 to reg 7 and 0x3C to reg 6 simultaneously -> both read back correctly next cycle with no Collision.

Source files
------------

// File: rtl/grf_multiport.sv
// rtl/grf_multiport.sv - two-read/two-write register file with busy scoreboard and write bypass
// Write port 1 (A4) beats port 0 (A3) on the same address; SetBusy beats a write's busy-clear.
module grf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] Wd3,
    input  logic              We3,
    input  logic [ADDR_W-1:0] A4,
    input  logic [DATA_W-1:0] Wd4,
    input  logic              We4,
    input  logic              SetBusy,
    input  logic [ADDR_W-1:0] SetAddr,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Collision
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH] = '{default: '0};
    logic [DEPTH-1:0]  r_busy      = '0;
    logic              r_collision = 1'b0;

    logic w_zero1, w_zero2, w_zero3, w_zero4, w_zero_set;
    logic w_we3_eff, w_we4_eff, w_set_eff;

    assign w_zero1    = (ZERO_REG != 0) && (A1 == '0);
    assign w_zero2    = (ZERO_REG != 0) && (A2 == '0);
    assign w_zero3    = (ZERO_REG != 0) && (A3 == '0);
    assign w_zero4    = (ZERO_REG != 0) && (A4 == '0);
    assign w_zero_set = (ZERO_REG != 0) && (SetAddr == '0);

    assign w_we3_eff = We3 && !Reset && !w_zero3;
    assign w_we4_eff = We4 && !Reset && !w_zero4;
    assign w_set_eff = SetBusy && !Reset && !w_zero_set;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy      <= '0;
            r_collision <= 1'b0;
        end else begin
            // Port 1 is written last so it overrides port 0 on an address clash.
            if (w_we3_eff) r_regs[A3] <= Wd3;
            if (w_we4_eff) r_regs[A4] <= Wd4;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_set_eff && SetAddr == ADDR_W'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_we3_eff && A3 == ADDR_W'(i)) ||
                             (w_we4_eff && A4 == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_collision <= w_we3_eff && w_we4_eff && (A3 == A4);
        end
    end

    always_comb begin
        Rd1 = r_regs[A1];
        if (w_zero1) begin
            Rd1 = '0;
        end else if (BYPASS != 0 && w_we4_eff && A4 == A1) begin
            Rd1 = Wd4;
        end else if (BYPASS != 0 && w_we3_eff && A3 == A1) begin
            Rd1 = Wd3;
        end
    end

    always_comb begin
        Rd2 = r_regs[A2];
        if (w_zero2) begin
            Rd2 = '0;
        end else if (BYPASS != 0 && w_we4_eff && A4 == A2) begin
            Rd2 = Wd4;
        end else if (BYPASS != 0 && w_we3_eff && A3 == A2) begin
            Rd2 = Wd3;
        end
    end

    // Busy flags come from stored state only; same-cycle set/clear is not visible.
    assign Busy1     = r_busy[A1] && !w_zero1;
    assign Busy2     = r_busy[A2] && !w_zero2;
    assign Collision = r_collision;

endmodule

// File: tb/tb_grf_multiport.sv
// tb/tb_grf_multiport.sv - randomized and directed checks of grf_multiport against a behavioural model
module tb_grf_multiport;
    logic        Clk = 1'b0;
    logic        Reset, We3, We4, SetBusy;
    logic [4:0]  A1, A2, A3, A4, SetAddr;
    logic [31:0] Wd3, Wd4, Rd1, Rd2;
    logic        Busy1, Busy2, Collision;

    logic        b_reset, b_we3, b_we4, b_setbusy;
    logic [2:0]  b_a1, b_a2, b_a3, b_a4, b_setaddr;
    logic [7:0]  b_wd3, b_wd4, b_rd1, b_rd2;
    logic        b_busy1, b_busy2, b_collision;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem_m [32];
    bit          busy_m [32];
    bit          coll_m;

    always #5 Clk = ~Clk;

    grf_multiport dut (
        .Clk(Clk), .Reset(Reset), .A1(A1), .A2(A2), .Rd1(Rd1), .Rd2(Rd2),
        .A3(A3), .Wd3(Wd3), .We3(We3), .A4(A4), .Wd4(Wd4), .We4(We4),
        .SetBusy(SetBusy), .SetAddr(SetAddr), .Busy1(Busy1), .Busy2(Busy2),
        .Collision(Collision)
    );

    grf_multiport #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_small (
        .Clk(Clk), .Reset(b_reset), .A1(b_a1), .A2(b_a2), .Rd1(b_rd1), .Rd2(b_rd2),
        .A3(b_a3), .Wd3(b_wd3), .We3(b_we3), .A4(b_a4), .Wd4(b_wd4), .We4(b_we4),
        .SetBusy(b_setbusy), .SetAddr(b_setaddr), .Busy1(b_busy1), .Busy2(b_busy2),
        .Collision(b_collision)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit eff3();
        return We3 && !Reset && A3 != 0;
    endfunction

    function automatic bit eff4();
        return We4 && !Reset && A4 != 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (eff4() && A4 == a) return Wd4;
        if (eff3() && A3 == a) return Wd3;
        return mem_m[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        return {31'h0, (a != 0) && busy_m[a]};
    endfunction

    task automatic idle();
        Reset = 1'b0; We3 = 1'b0; We4 = 1'b0; SetBusy = 1'b0;
    endtask

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic step();
        bit e3, e4, es;
        #2;
        check("rd1", Rd1, exp_rd(A1));
        check("rd2", Rd2, exp_rd(A2));
        check("busy1", {31'h0, Busy1}, exp_busy(A1));
        check("busy2", {31'h0, Busy2}, exp_busy(A2));
        check("collision", {31'h0, Collision}, {31'h0, coll_m});
        e3 = eff3();
        e4 = eff4();
        es = SetBusy && !Reset && SetAddr != 0;
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_m[i] = 32'h0;
                busy_m[i] = 1'b0;
            end
            coll_m = 1'b0;
        end else begin
            if (e3) mem_m[A3] = Wd3;
            if (e4) mem_m[A4] = Wd4;
            if (e3) busy_m[A3] = 1'b0;
            if (e4) busy_m[A4] = 1'b0;
            if (es) busy_m[SetAddr] = 1'b1;
            coll_m = e3 && e4 && (A3 == A4);
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_m[i] = 32'h0;
            busy_m[i] = 1'b0;
        end
        coll_m = 1'b0;
        A1 = 0; A2 = 0; A3 = 0; A4 = 0; SetAddr = 0; Wd3 = 0; Wd4 = 0;
        idle();
        b_reset = 1'b1; b_we3 = 1'b0; b_we4 = 1'b0; b_setbusy = 1'b0;
        b_a1 = 0; b_a2 = 0; b_a3 = 0; b_a4 = 0; b_setaddr = 0; b_wd3 = 0; b_wd4 = 0;
        #1;

        Reset = 1'b1;
        step();
        step();
        idle();
        b_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            step();
        end

        // Single write, bypass visible in the write cycle
        We3 = 1'b1; A3 = 5; Wd3 = 32'h1234; A1 = 5;
        #1 check("bypass_rd1", Rd1, 32'h1234);
        step();
        idle();
        #1 check("stored_rd1", Rd1, 32'h1234);
        step();

        // Same-address dual write: port 1 wins, Collision pulses once
        We3 = 1'b1; We4 = 1'b1; A3 = 7; A4 = 7; Wd3 = 32'hAAAA; Wd4 = 32'h5555; A1 = 7;
        step();
        idle();
        #1 check("coll_set", {31'h0, Collision}, 32'h1);
        check("reg7", Rd1, 32'h5555);
        step();
        #1 check("coll_clear", {31'h0, Collision}, 32'h0);
        step();

        // Register zero ignores writes and busy-sets
        We4 = 1'b1; A4 = 0; Wd4 = 32'hFFFF; SetBusy = 1'b1; SetAddr = 0; A1 = 0;
        step();
        idle();
        #1 check("zero_rd1", Rd1, 32'h0);
        check("zero_busy1", {31'h0, Busy1}, 32'h0);
        step();

        // Busy set, cleared by a write, and set winning over a same-cycle write
        SetBusy = 1'b1; SetAddr = 9; A2 = 9;
        step();
        idle();
        #1 check("busy_set", {31'h0, Busy2}, 32'h1);
        We3 = 1'b1; A3 = 9; Wd3 = 32'h99;
        step();
        idle();
        #1 check("busy_cleared", {31'h0, Busy2}, 32'h0);
        We3 = 1'b1; A3 = 9; Wd3 = 32'h9A; SetBusy = 1'b1; SetAddr = 9;
        step();
        idle();
        #1 check("busy_set_wins", {31'h0, Busy2}, 32'h1);
        step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            A1 = 5'($urandom); A2 = 5'($urandom); A3 = 5'($urandom);
            A4 = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            Wd3 = $urandom; Wd4 = $urandom;
            We3 = 1'($urandom); We4 = 1'($urandom);
            SetBusy = 1'($urandom);
            SetAddr = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
            Reset = ($urandom_range(0, 60) == 0);
            step();
        end
        idle();

        // Load everything then reset in the middle of a write burst
        for (int i = 1; i < 32; i++) begin
            We3 = 1'b1; A3 = 5'(i); Wd3 = 32'(i) * 32'h01010101 + 32'h1;
            SetBusy = 1'b1; SetAddr = 5'(i);
            step();
        end
        Reset = 1'b1; We3 = 1'b1; We4 = 1'b1; A3 = 3; A4 = 3; Wd3 = 32'h33; Wd4 = 32'h44;
        SetBusy = 1'b1; SetAddr = 4;
        step();
        idle();
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(i);
            #1 check("rst_rd1", Rd1, 32'h0);
            check("rst_busy2", {31'h0, Busy2}, 32'h0);
            check("rst_coll", {31'h0, Collision}, 32'h0);
            step();
        end

        // Narrow, no-bypass instance: two writes to different registers
        b_we3 = 1'b1; b_a3 = 7; b_wd3 = 8'hC3;
        b_we4 = 1'b1; b_a4 = 6; b_wd4 = 8'h3C;
        b_a1 = 7; b_a2 = 6;
        #1 check("small_nobypass_rd1", {24'h0, b_rd1}, 32'h0);
        check("small_nobypass_rd2", {24'h0, b_rd2}, 32'h0);
        @(posedge Clk);
        #1;
        b_we3 = 1'b0; b_we4 = 1'b0;
        #1 check("small_rd1", {24'h0, b_rd1}, 32'hC3);
        check("small_rd2", {24'h0, b_rd2}, 32'h3C);
        check("small_coll", {31'h0, b_collision}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
